// File: rtl/uart_reg_responder_pkg.sv
// Shared definitions for the UART register responder: state encodings,
// reply bytes, opcode defaults and a ceiling-log2 helper shared with the UART.
package uart_reg_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_DO_READ   = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_BUSY = 3'd5,
        ST_WAIT_DONE = 3'd6
    } resp_state_e;

    localparam logic [7:0] REPLY_ACK = 8'h4B;
    localparam logic [7:0] REPLY_NAK = 8'h3F;

    localparam logic [7:0] OP_WRITE_DEFAULT = 8'h57;
    localparam logic [7:0] OP_READ_DEFAULT  = 8'h52;

    localparam int unsigned TIMEOUT_DEFAULT = 520830;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_resp_timeout.sv
// Inter-byte timeout: a loadable down-counter that reloads on clear and
// flags expiry while enabled once it has run down to zero.
module uart_resp_timeout
    import uart_reg_responder_pkg::*;
#(
    parameter int unsigned cycles = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = log2_ceil(cycles);
    // Expiry is seen two clocks before the registered abort becomes visible,
    // so frame_error lands exactly cycles-1 clocks after the last byte.
    localparam logic [W-1:0] LOAD = W'(cycles - 3);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= LOAD;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/uart_reg_responder.sv
// Serial peek/poke responder: parses 'W' addr data / 'R' addr frames from the
// UART, drives a strobe register bus, and returns one reply byte per frame.
module uart_reg_responder
    import uart_reg_responder_pkg::*;
#(
    parameter int unsigned timeout_cycles = TIMEOUT_DEFAULT,
    parameter logic [7:0]  op_write       = OP_WRITE_DEFAULT,
    parameter logic [7:0]  op_read        = OP_READ_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_error,
    output logic [7:0] err_count,
    output logic [2:0] resp_state
);

    resp_state_e state_q;
    logic        op_is_write_q;
    logic        transmit_q;
    logic [7:0]  tx_byte_q;
    logic [7:0]  reg_addr_q;
    logic [7:0]  reg_wdata_q;
    logic        reg_we_q;
    logic        reg_re_q;
    logic        frame_error_q;
    logic [7:0]  err_count_q;
    logic [7:0]  err_count_d;

    logic in_frame;
    logic tmo_expire;
    logic abort;
    logic err_bump;

    assign in_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

    uart_resp_timeout #(.cycles(timeout_cycles)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (received || !in_frame),
        .en_i     (in_frame),
        .expire_o (tmo_expire)
    );

    // A byte arriving on the expiry cycle rescues the frame; a framing error never does.
    assign abort    = in_frame && (recv_error || (tmo_expire && !received));
    assign err_bump = recv_error || abort;

    always_comb begin
        err_count_d = err_count_q;
        if (err_bump && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_is_write_q <= 1'b0;
            transmit_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            reg_addr_q    <= 8'h00;
            reg_wdata_q   <= 8'h00;
            reg_we_q      <= 1'b0;
            reg_re_q      <= 1'b0;
            frame_error_q <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            transmit_q    <= 1'b0;
            reg_we_q      <= 1'b0;
            reg_re_q      <= 1'b0;
            frame_error_q <= 1'b0;
            err_count_q   <= err_count_d;
            case (state_q)
                ST_IDLE: begin
                    if (received && !recv_error) begin
                        if ((rx_byte == op_write) || (rx_byte == op_read)) begin
                            op_is_write_q <= (rx_byte == op_write);
                            state_q       <= ST_GET_ADDR;
                        end else begin
                            tx_byte_q <= REPLY_NAK;
                            state_q   <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (abort) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (received) begin
                        reg_addr_q <= rx_byte;
                        if (op_is_write_q) begin
                            state_q <= ST_GET_DATA;
                        end else begin
                            reg_re_q <= 1'b1;
                            state_q  <= ST_DO_READ;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (abort) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (received) begin
                        reg_wdata_q <= rx_byte;
                        reg_we_q    <= 1'b1;
                        tx_byte_q   <= REPLY_ACK;
                        state_q     <= ST_SEND;
                    end
                end
                ST_DO_READ: begin
                    // First cycle carries reg_re; read data is valid on the second,
                    // which also issues the send so the reply leaves three clocks after the address.
                    if (!reg_re_q) begin
                        tx_byte_q <= reg_rdata;
                        if (!is_transmitting) begin
                            transmit_q <= 1'b1;
                            state_q    <= ST_WAIT_BUSY;
                        end else begin
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (!is_transmitting) begin
                        transmit_q <= 1'b1;
                        state_q    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (is_transmitting) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!is_transmitting) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign transmit    = transmit_q;
    assign tx_byte     = tx_byte_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_we      = reg_we_q;
    assign reg_re      = reg_re_q;
    assign frame_error = frame_error_q;
    assign err_count   = err_count_q;
    assign resp_state  = state_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: a table of complete frames plus
// hand-written sequences for timeout, busy, error, saturation and reset.
module tb_uart_reg_responder;

    logic       clk;
    logic       rst_n;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_error;
    logic [7:0] err_count;
    logic [2:0] resp_state;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        logic [7:0] rdata;
        int         we_off;
        int         re_off;
        int         tx_off;
        logic [7:0] tx;
        logic [7:0] addr;
        logic [7:0] wdata;
    } vec_t;

    vec_t vecs[6];

    uart_reg_responder #(.timeout_cycles(100)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_we          (reg_we),
        .reg_re          (reg_re),
        .reg_rdata       (reg_rdata),
        .frame_error     (frame_error),
        .err_count       (err_count),
        .resp_state      (resp_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".transmit"},    32'(transmit),    32'h0);
        check({tag, ".tx_byte"},     32'(tx_byte),     32'h0);
        check({tag, ".reg_addr"},    32'(reg_addr),    32'h0);
        check({tag, ".reg_wdata"},   32'(reg_wdata),   32'h0);
        check({tag, ".reg_we"},      32'(reg_we),      32'h0);
        check({tag, ".reg_re"},      32'(reg_re),      32'h0);
        check({tag, ".frame_error"}, 32'(frame_error), 32'h0);
        check({tag, ".err_count"},   32'(err_count),   32'h0);
        check({tag, ".resp_state"},  32'(resp_state),  32'h0);
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        tick();
        received = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic pulse_recv_error();
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        tick();
    endtask

    // Watches the cycles after the last frame byte, plays the register bus and
    // the UART transmitter, and compares strobes and the reply against v.
    task automatic observe(input vec_t v, input string tag);
        int we_cnt = 0, re_cnt = 0, tx_cnt = 0;
        int we_at = 0, re_at = 0, tx_at = 0, bsy = 0;
        logic prev_re = 1'b0;
        logic [7:0] got_tx = 8'h00;
        logic [7:0] exp_tx;
        if (v.tx_off != 0) exp_q.push_back(v.tx);
        for (int off = 1; off <= 12; off++) begin
            reg_rdata = prev_re ? v.rdata : 8'hEE;
            if (bsy > 0) begin
                is_transmitting = 1'b1;
                bsy--;
            end else begin
                is_transmitting = 1'b0;
            end
            if (reg_we) begin we_cnt++; we_at = off; end
            if (reg_re) begin re_cnt++; re_at = off; end
            if (transmit) begin
                tx_cnt++;
                tx_at = off;
                got_tx = tx_byte;
                is_transmitting = 1'b1;
                bsy = 3;
            end
            prev_re = reg_re;
            tick();
        end
        is_transmitting = 1'b0;
        reg_rdata = 8'h00;
        check({tag, ".we_cnt"}, 32'(we_cnt), (v.we_off != 0) ? 32'd1 : 32'd0);
        check({tag, ".we_at"},  32'(we_at),  32'(v.we_off));
        check({tag, ".re_cnt"}, 32'(re_cnt), (v.re_off != 0) ? 32'd1 : 32'd0);
        check({tag, ".re_at"},  32'(re_at),  32'(v.re_off));
        check({tag, ".tx_cnt"}, 32'(tx_cnt), (v.tx_off != 0) ? 32'd1 : 32'd0);
        check({tag, ".tx_at"},  32'(tx_at),  32'(v.tx_off));
        if (v.tx_off != 0 && exp_q.size() > 0) begin
            exp_tx = exp_q.pop_front();
            check({tag, ".tx_byte"}, 32'(got_tx), 32'(exp_tx));
        end
        check({tag, ".reg_addr"},   32'(reg_addr),   32'(v.addr));
        check({tag, ".reg_wdata"},  32'(reg_wdata),  32'(v.wdata));
        check({tag, ".err_count"},  32'(err_count),  32'(exp_err));
        check({tag, ".resp_state"}, 32'(resp_state), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_byte(v.b0);
        if (v.n > 1) send_byte(v.b1);
        if (v.n > 2) send_byte(v.b2);
        observe(v, tag);
    endtask

    initial begin
        vec_t v;
        int fe_cnt, fe_at, bad_cnt, tx_cnt;

        //              b0     b1     b2   n  rdata  we re tx  tx     addr   wdata
        vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 8'h00, 1, 0, 2, 8'h4B, 8'h10, 8'hA5};
        vecs[1] = '{8'h52, 8'h22, 8'h00, 2, 8'h3C, 0, 1, 3, 8'h3C, 8'h22, 8'hA5};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 0, 2, 8'h3F, 8'h22, 8'hA5};
        vecs[3] = '{8'h57, 8'hFF, 8'h00, 3, 8'h00, 1, 0, 2, 8'h4B, 8'hFF, 8'h00};
        vecs[4] = '{8'h52, 8'h80, 8'h00, 2, 8'h5A, 0, 1, 3, 8'h5A, 8'h80, 8'h00};
        vecs[5] = '{8'h72, 8'h00, 8'h00, 1, 8'h00, 0, 0, 2, 8'h3F, 8'h80, 8'h00};

        rst_n = 1'b0;
        received = 1'b0;
        rx_byte = 8'h00;
        recv_error = 1'b0;
        is_transmitting = 1'b0;
        reg_rdata = 8'h00;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // A byte landing on the expiry cycle keeps the frame alive.
        send_byte(8'h57);
        repeat (97) tick();
        check("edge.frame_error", 32'(frame_error), 32'h0);
        check("edge.state", 32'(resp_state), 32'd1);
        send_byte(8'h20);
        check("edge.frame_error_after", 32'(frame_error), 32'h0);
        check("edge.state_after", 32'(resp_state), 32'd2);
        send_byte(8'h77);
        observe('{8'h00, 8'h00, 8'h00, 0, 8'h00, 1, 0, 2, 8'h4B, 8'h20, 8'h77}, "edge");

        // Silence after the address: abort timeout_cycles-1 clocks after the last byte.
        send_byte(8'h57);
        send_byte(8'h10);
        fe_cnt = 0;
        fe_at = 0;
        bad_cnt = 0;
        for (int off = 1; off <= 105; off++) begin
            if (frame_error) begin fe_cnt++; fe_at = off; end
            if (transmit || reg_we || reg_re) bad_cnt++;
            if (off == 50) check("tmo.mid_state", 32'(resp_state), 32'd2);
            tick();
        end
        exp_err = 1;
        check("tmo.fe_cnt", 32'(fe_cnt), 32'd1);
        check("tmo.fe_at", 32'(fe_at), 32'd99);
        check("tmo.no_strobes", 32'(bad_cnt), 32'd0);
        check("tmo.err_count", 32'(err_count), 32'(exp_err));
        check("tmo.state", 32'(resp_state), 32'd0);
        run_vec('{8'h52, 8'h10, 8'h00, 2, 8'hC3, 0, 1, 3, 8'hC3, 8'h10, 8'h77}, "after_tmo");

        // Reply withheld while the transmitter is busy.
        is_transmitting = 1'b1;
        reg_rdata = 8'h99;
        send_byte(8'h52);
        send_byte(8'h33);
        check("busy.reg_re", 32'(reg_re), 32'h1);
        tx_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (transmit) tx_cnt++;
            tick();
        end
        check("busy.withheld", 32'(tx_cnt), 32'd0);
        check("busy.state", 32'(resp_state), 32'd4);
        check("busy.reg_addr", 32'(reg_addr), 32'h33);
        is_transmitting = 1'b0;
        tick();
        check("busy.transmit", 32'(transmit), 32'h1);
        check("busy.tx_byte", 32'(tx_byte), 32'h99);
        is_transmitting = 1'b1;
        tick();
        check("busy.transmit_once", 32'(transmit), 32'h0);
        repeat (2) tick();
        is_transmitting = 1'b0;
        repeat (2) tick();
        check("busy.state_end", 32'(resp_state), 32'd0);
        reg_rdata = 8'h00;

        // recv_error in IDLE only counts.
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        exp_err = 2;
        check("rerr_idle.err_count", 32'(err_count), 32'(exp_err));
        check("rerr_idle.frame_error", 32'(frame_error), 32'h0);
        check("rerr_idle.state", 32'(resp_state), 32'd0);
        tick();

        // recv_error in GET_DATA, together with a byte: error wins, one abort.
        send_byte(8'h57);
        send_byte(8'h44);
        received = 1'b1;
        rx_byte = 8'h55;
        recv_error = 1'b1;
        tick();
        received = 1'b0;
        rx_byte = 8'h00;
        recv_error = 1'b0;
        exp_err = 3;
        check("rerr_data.frame_error", 32'(frame_error), 32'h1);
        check("rerr_data.state", 32'(resp_state), 32'd0);
        check("rerr_data.reg_we", 32'(reg_we), 32'h0);
        check("rerr_data.err_count", 32'(err_count), 32'(exp_err));
        tick();
        check("rerr_data.fe_once", 32'(frame_error), 32'h0);
        check("rerr_data.err_once", 32'(err_count), 32'(exp_err));
        check("rerr_data.reg_wdata", 32'(reg_wdata), 32'h77);
        check("rerr_data.reg_addr", 32'(reg_addr), 32'h44);
        check("rerr_data.no_tx", 32'(transmit), 32'h0);

        // Saturation of the error counter.
        repeat (251) pulse_recv_error();
        check("sat.below", 32'(err_count), 32'hFE);
        repeat (9) pulse_recv_error();
        check("sat.held", 32'(err_count), 32'hFF);

        // Asynchronous reset while waiting for the transmitter to go busy.
        send_byte(8'h00);
        tick();
        check("rst.transmit_before", 32'(transmit), 32'h1);
        check("rst.state_before", 32'(resp_state), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst.state_after", 32'(resp_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
